// File: rtl/mau_core_param.sv
// Parametrised math accelerator core: chunk-streamed operands, ADD/SUB/MUL/MAC, chunk-streamed result.
// Optional signed arithmetic is enabled by defining MAU_SIGNED_EN.
module mau_core_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CHUNK_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               acc_clr,
    input  logic               op_signed,
    input  logic               in_valid,
    input  logic [CHUNK_W-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CHUNK_W-1:0] out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               ovf
);
    localparam int unsigned RES_W     = 2 * DATA_W;
    localparam int unsigned IN_BEATS  = DATA_W / CHUNK_W;
    localparam int unsigned OUT_BEATS = RES_W / CHUNK_W;
    localparam int unsigned CNT_W     = $clog2(RES_W);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sgn_q, sgn_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   acc_q, acc_d, res_q, res_d;
    logic [RES_W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic               ovf_q, ovf_d, out_valid_q, out_valid_d;

    logic [RES_W-1:0]   a_ext, b_ext, sum, diff, prod_nx;
    logic [RES_W:0]     mac;
    logic               last_step;

`ifndef MAU_SIGNED_EN
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sgn_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sgn_q       <= sgn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath helpers; the last multiply step subtracts when the multiplier MSB is a sign bit.
    always_comb begin
        a_ext     = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
        b_ext     = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
        sum       = a_ext + b_ext;
        diff      = a_ext - b_ext;
        last_step = (cnt_q == CNT_W'(DATA_W - 1));
        if (last_step && sgn_q && b_q[0]) prod_nx = prod_q - mcand_q;
        else                              prod_nx = prod_q + (b_q[0] ? mcand_q : '0);
        mac       = {1'b0, acc_q} + {1'b0, prod_nx};
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sgn_d       = sgn_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (acc_clr) acc_d = '0;
                if (start) begin
                    op_d    = op;
`ifdef MAU_SIGNED_EN
                    sgn_d   = op_signed;
`else
                    sgn_d   = 1'b0;
`endif
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (in_valid) begin
                    a_d   = DATA_W'({in_data, a_q} >> CHUNK_W);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(IN_BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    b_d   = DATA_W'({in_data, b_q} >> CHUNK_W);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(IN_BEATS - 1)) begin
                        cnt_d   = '0;
                        mcand_d = a_ext;
                        prod_d  = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!op_q[1]) begin
                    res_d       = op_q[0] ? diff : sum;
                    if (sgn_q && !op_q[0])
                        ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
                    else if (sgn_q)
                        ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
                    else if (!op_q[0])
                        ovf_d = sum[DATA_W];
                    else
                        ovf_d = (a_q < b_q);
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    prod_d  = prod_nx;
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = DRAIN;
                        if (op_q[0]) begin
                            acc_d = mac[RES_W-1:0];
                            res_d = mac[RES_W-1:0];
                            ovf_d = mac[RES_W];
                        end else begin
                            res_d = prod_nx;
                            ovf_d = 1'b0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    res_d = res_q >> CHUNK_W;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(OUT_BEATS - 1)) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = res_q[CHUNK_W-1:0];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mau_core_param.sv
// Bench for mau_core_param: random transactions checked beat-by-beat against an arithmetic model.
module tb_mau_core_param;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CHUNK_W   = 4;
    localparam int unsigned RES_W     = 2 * DATA_W;
    localparam int unsigned IN_BEATS  = DATA_W / CHUNK_W;
    localparam int unsigned OUT_BEATS = RES_W / CHUNK_W;
`ifdef MAU_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, start, acc_clr, op_signed, in_valid, out_ready;
    logic [1:0]         op;
    logic [CHUNK_W-1:0] in_data, out_data;
    logic               in_ready, out_valid, busy, ovf;

    mau_core_param #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .acc_clr(acc_clr),
        .op_signed(op_signed), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [RES_W-1:0] res; logic ovf; } exp_t;
    exp_t             exp_q[$];
    longint           acc_m;
    int               errors = 0;
    int               checks = 0;
    int               beat_idx = 0;
    logic [RES_W-1:0] cur_res, got_res, last_res;
    logic             last_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    task automatic model(input logic [1:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic sgn, output exp_t e);
        longint full, va, vb, s, smax, smin;
        full = longint'(1) << RES_W;
        smax = (longint'(1) << (DATA_W - 1)) - 1;
        smin = -(longint'(1) << (DATA_W - 1));
        va = longint'(a);
        vb = longint'(b);
        if (sgn && a[DATA_W-1]) va = va - (longint'(1) << DATA_W);
        if (sgn && b[DATA_W-1]) vb = vb - (longint'(1) << DATA_W);
        e.ovf = 1'b0;
        case (o)
            2'd0: begin
                s = va + vb;
                e.ovf = sgn ? (s > smax || s < smin) : (s >= (longint'(1) << DATA_W));
            end
            2'd1: begin
                s = va - vb;
                e.ovf = sgn ? (s > smax || s < smin) : (a < b);
            end
            2'd2: s = va * vb;
            default: begin
                s = acc_m + ((va * vb) & (full - 1));
                e.ovf = (s >= full);
                acc_m = s & (full - 1);
            end
        endcase
        e.res = RES_W'(s & (full - 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_operand(input logic [DATA_W-1:0] v);
        for (int i = 0; i < int'(IN_BEATS); i++) begin
            int n;
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                in_data  = CHUNK_W'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = v[i*CHUNK_W +: CHUNK_W];
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_txn(input logic [1:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic clr, input logic sgn, input bit bp);
        exp_t e;
        int   lat, n;
        wait_idle();
        if (clr) acc_m = 0;
        model(o, a, b, SGN_EN && sgn, e);
        exp_q.push_back(e);
        start = 1'b1; op = o; acc_clr = clr; op_signed = sgn;
        tick();
        start = 1'b0; acc_clr = 1'b0;
        send_operand(a);
        send_operand(b);
        // Stray in_valid/start pulses while executing must be ignored.
        lat = 0;
        while (!out_valid && lat < int'(DATA_W) + 4) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = CHUNK_W'($urandom);
            start    = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("latency", 64'(lat), o[1] ? 64'(DATA_W) : 64'd1);
        n = 0;
        while (busy && n < 200) begin
            out_ready = (bp && n < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            start     = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (busy) check("drain_timeout", 64'(busy), 64'd0);
    endtask

    // Output checker: every valid beat against the model's expected chunk and flag.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat_idx = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                cur_res = exp_q[0].res;
                check("out_data", 64'(out_data), 64'(CHUNK_W'(cur_res >> (beat_idx * CHUNK_W))));
                check("ovf", 64'(ovf), 64'(exp_q[0].ovf));
                if (out_ready) begin
                    got_res[beat_idx*CHUNK_W +: CHUNK_W] = out_data;
                    beat_idx++;
                    if (beat_idx == int'(OUT_BEATS)) begin
                        last_res = got_res;
                        last_ovf = ovf;
                        void'(exp_q.pop_front());
                        beat_idx = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; acc_clr = 1'b0; op_signed = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        acc_m = 0; got_res = '0; last_res = '0; last_ovf = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        run_txn(2'd0, 8'hF0, 8'h25, 1'b0, 1'b0, 1'b0);
        check("add_res", 64'(last_res), 64'h0115);
        check("add_ovf", 64'(last_ovf), 64'd1);
        run_txn(2'd1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        check("sub_res", 64'(last_res), 64'hFFF0);
        check("sub_ovf", 64'(last_ovf), 64'd1);
        run_txn(2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("mul_res", 64'(last_res), 64'hFE01);
        check("mul_ovf", 64'(last_ovf), 64'd0);
        run_txn(2'd3, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        check("mac1_res", 64'(last_res), 64'h4000);
        run_txn(2'd3, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        check("mac2_res", 64'(last_res), 64'h8000);
        run_txn(2'd3, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("mac3_res", 64'(last_res), 64'h7E01);
        check("mac3_ovf", 64'(last_ovf), 64'd1);
        run_txn(2'd0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("bp_res", 64'(last_res), 64'h0096);

        // Abort a MUL four cycles into execution.
        wait_idle();
        start = 1'b1; op = 2'd2; acc_clr = 1'b0; op_signed = 1'b0;
        tick();
        start = 1'b0;
        send_operand(8'hA5);
        send_operand(8'h5A);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        acc_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        run_txn(2'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        check("post_rst_add", 64'(last_res), 64'h0046);
        run_txn(2'd3, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
        check("post_rst_acc", 64'(last_res), 64'h0006);

`ifdef MAU_SIGNED_EN
        run_txn(2'd2, 8'hFF, 8'h02, 1'b0, 1'b1, 1'b0);
        check("smul_res", 64'(last_res), 64'hFFFE);
        run_txn(2'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        check("sadd_ovf", 64'(last_ovf), 64'd1);
`endif

        for (int t = 0; t < 60; t++) begin
            run_txn(2'($urandom_range(0, 3)), DATA_W'($urandom), DATA_W'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end
        wait_idle();
        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mau_core_param.md
Name: mau_core_param

Overview:
Parametrised math accelerator core, the next generation of the 4-bit MAU. Operands of DATA_W bits are streamed in CHUNK_W-bit beats. The core executes ADD/SUB/MUL/MAC, MUL and MAC through a multi-cycle shift-add unit. It streams the 2*DATA_W-bit result back over a valid/ready port. It sits behind the TinyTapeout pin wrapper, which maps ui_in/uo_out/uio onto its chunk ports.

Parameters:
DATA_W, 8, operand width in bits; multiple of CHUNK_W, range 4..16
CHUNK_W, 4, beat width in bits; 4 or 8
(derived) RES_W = 2*DATA_W; IN_BEATS = DATA_W/CHUNK_W; OUT_BEATS = RES_W/CHUNK_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin transaction; sampled only in IDLE
op  in  2  00 ADD, 01 SUB, 10 MUL, 11 MAC; latched on accepted start
acc_clr  in  1  clears MAC accumulator; honoured only in IDLE
op_signed  in  1  signed mode select (used only with MAU_SIGNED_EN)
in_valid  in  1  operand beat valid
in_data  in  CHUNK_W  operand beat, least-significant chunk first
in_ready  out  1  core accepts operand beat
out_valid  out  1  result beat valid
out_data  out  CHUNK_W  result beat, least-significant chunk first
out_ready  in  1  consumer accepts result beat
busy  out  1  state != IDLE
ovf  out  1  overflow/borrow flag of current result; held until next start

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst.
- On rst: state IDLE; in_ready, out_valid, out_data, busy and ovf are all 0; operand registers, beat counter, accumulator and result are all 0.
- rst asserted mid-operation aborts immediately. There is no partial output after release.
- FSM states are IDLE, LOAD_A, LOAD_B, EXEC, DRAIN.
- IDLE:
  - start=1 latches op and goes to LOAD_A.
  - acc_clr=1 zeroes the accumulator; if start is also 1, the clear happens first.
  - start outside IDLE is ignored.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - Each beat with in_valid&&in_ready shifts in at the MS end, so the first beat lands as the LS chunk.
  - After IN_BEATS beats: LOAD_A goes to LOAD_B, LOAD_B goes to EXEC. The counter resets per operand.
- EXEC:
  - in_ready=0.
  - ADD/SUB take 1 cycle. MUL/MAC take exactly DATA_W cycles (one shift-add step per cycle).
  - The result register and ovf update on the final EXEC edge, then the FSM goes to DRAIN.
- Arithmetic (unsigned default; operands zero-extended to RES_W):
  - ADD: result = A+B; ovf = carry out of bit DATA_W-1.
  - SUB: result = (A-B) mod 2^RES_W; ovf = 1 iff A<B.
  - MUL: result = A*B; ovf = 0.
  - MAC: acc = (acc + A*B) mod 2^RES_W; result = new acc; ovf = carry out of RES_W.
- Latency: the last B beat is accepted at edge k. out_valid=1 after edge k+1 for ADD/SUB, and after edge k+DATA_W for MUL/MAC.
- DRAIN:
  - out_valid=1 and out_data = the current chunk.
  - The chunk advances on out_valid&&out_ready.
  - While out_ready=0, out_data is held stable.
  - Acceptance of beat OUT_BEATS-1 returns the FSM to IDLE and clears out_valid on the same edge.
- in_valid outside LOAD states has no effect.
- The accumulator persists across transactions. Only rst or acc_clr clear it.

Optional Feature:
MAU_SIGNED_EN
- Defined: when op_signed=1 is latched with start, operands are two's complement and are sign-extended to RES_W.
  - MUL/MAC produce a signed product via Booth-free sign-corrected shift-add, same cycle count.
  - ADD/SUB ovf becomes signed overflow of a DATA_W-bit result.
- Undefined: op_signed is ignored, the logic is absent, and all ops are unsigned.

Test Plan:
- ADD (DATA_W=8, CHUNK_W=4): A=0xF0 (beats 0,F), B=0x25 (beats 5,2) -> out beats 5,1,1,0 (0x0115); ovf=1; out_valid 1 cycle after last B beat.
- SUB: A=0x10, B=0x20 -> result 0xFFF0, beats 0,F,F,F; ovf=1.
- MUL: A=0xFF, B=0xFF -> 0xFE01; out_valid exactly 8 cycles after last B beat; ovf=0.
- MAC: acc_clr, then MAC 0x80*0x80 -> 0x4000; repeat -> 0x8000; then 0xFF*0xFF -> 0x7E01 with ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_data/out_valid stable; in_valid pulses during EXEC ignored; start during DRAIN ignored.
- Reset: assert rst for 1 cycle at EXEC cycle 4 of a MUL -> busy/out_valid/ovf=0 immediately, accumulator 0; a new ADD afterwards completes correctly.
- (MAU_SIGNED_EN) op_signed=1, MUL 0xFF*0x02 -> 0xFFFE; ADD 0x7F+0x01 -> ovf=1.
